// File: rtl/direct_cache_ctrl.sv
// ---------------------------------------------------------------------------
// direct_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate cache controller with one
//   word per line. Owns the tag/valid arrays; the data array lives outside and
//   is driven through the cache_* port (written on the falling clock edge,
//   read combinationally).
//
//   Optional feature: define CACHE_STATS_EN to build saturating hit/miss
//   counters. Without it hit_count/miss_count are tied to zero.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/wdata CPU request, accepted while cpu_ready=1
//   cpu_ready             controller idle
//   cpu_done              one-cycle completion pulse
//   cpu_rdata, cpu_hit    read data / hit flag of the last completed access
//   mem_*                 main-memory request/acknowledge port
//   cache_*               external cache data array port
//   hit_count, miss_count statistics counters
// ---------------------------------------------------------------------------
module direct_cache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int CACHE_DEPTH = 8,
    localparam int IW = $clog2(CACHE_DEPTH),
    localparam int TW = ADDR_WIDTH - IW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cache_wr_en,
    output logic                  cache_rd_en,
    output logic [IW-1:0]         cache_index,
    output logic [DATA_WIDTH-1:0] cache_din,
    input  logic [DATA_WIDTH-1:0] cache_dout,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COMPARE = 3'd1;
    localparam logic [2:0] MEM_RD  = 3'd2;
    localparam logic [2:0] FILL    = 3'd3;
    localparam logic [2:0] MEM_WR  = 3'd4;
    localparam logic [2:0] UPDATE  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]             state, state_nxt;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  fetch_q;
    logic                   hit_q;
    logic [TW-1:0]          tag_arr [CACHE_DEPTH];
    logic [CACHE_DEPTH-1:0] valid_q;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag_in;
    logic          hit;

    assign idx    = addr_q[IW-1:0];
    assign tag_in = addr_q[ADDR_WIDTH-1:IW];
    assign hit    = valid_q[idx] && (tag_arr[idx] == tag_in);

    // All handshake/strobe outputs are pure decodes of the state register,
    // so mem_req and cache_wr_en are mutually exclusive by construction.
    assign cpu_ready   = (state == IDLE);
    assign cpu_done    = (state == DONE);
    assign mem_req     = (state == MEM_RD) || (state == MEM_WR);
    assign mem_we      = (state == MEM_WR);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cache_rd_en = (state == COMPARE);
    assign cache_wr_en = (state == FILL) || (state == UPDATE);
    assign cache_index = idx;
    assign cache_din   = (state == FILL) ? fetch_q : wdata_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req) state_nxt = COMPARE;
            COMPARE: begin
                if (we_q)     state_nxt = MEM_WR;
                else if (hit) state_nxt = DONE;
                else          state_nxt = MEM_RD;
            end
            MEM_RD:  if (mem_ack) state_nxt = FILL;
            FILL:    state_nxt = DONE;
            MEM_WR:  if (mem_ack) state_nxt = hit_q ? UPDATE : DONE;
            UPDATE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fetch_q   <= '0;
            hit_q     <= 1'b0;
            valid_q   <= '0;
            cpu_rdata <= '0;
            cpu_hit   <= 1'b0;
            for (int i = 0; i < CACHE_DEPTH; i++) tag_arr[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cpu_req) begin
                    we_q    <= cpu_we;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end
                COMPARE: begin
                    // hit_q remembers the lookup result for the write path,
                    // which only touches the data array on a hit.
                    hit_q <= hit;
                    if (!we_q && hit) begin
                        cpu_rdata <= cache_dout;
                        cpu_hit   <= 1'b1;
                    end
                end
                MEM_RD: if (mem_ack) fetch_q <= mem_rdata;
                FILL: begin
                    // Replacing a line never needs a write-back: memory is
                    // always current under write-through.
                    tag_arr[idx] <= tag_in;
                    valid_q[idx] <= 1'b1;
                    cpu_rdata    <= fetch_q;
                    cpu_hit      <= 1'b0;
                end
                MEM_WR: if (mem_ack && !hit_q) cpu_hit <= 1'b0;
                UPDATE: cpu_hit <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // cpu_hit is already settled for the current access while in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == DONE) begin
            if (cpu_hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_direct_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_direct_cache_ctrl
//   Directed + randomized bench for direct_cache_ctrl. The reference model is
//   a plain array of memory words plus a per-line {valid, tag} table; expected
//   read data is always the memory word (write-through keeps them coherent).
//   The bench also models the external data array and the memory responder.
// ---------------------------------------------------------------------------
module tb_direct_cache_ctrl;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int CD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready, cpu_done, cpu_hit;
    logic [DW-1:0] cpu_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          cache_wr_en, cache_rd_en;
    logic [2:0]    cache_index;
    logic [DW-1:0] cache_din, cache_dout;
    logic [15:0]   hit_count, miss_count;

    direct_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CACHE_DEPTH(CD)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cache_wr_en(cache_wr_en), .cache_rd_en(cache_rd_en), .cache_index(cache_index),
        .cache_din(cache_din), .cache_dout(cache_dout),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // External data array: falling-edge write, combinational read.
    logic [DW-1:0] carr [CD];
    always @(negedge clk) if (cache_wr_en) carr[cache_index] <= cache_din;
    assign cache_dout = carr[cache_index];

    // Reference model
    logic [DW-1:0] mem [256];
    logic          rv  [CD];
    logic [AW-4:0] rt  [CD];
    logic [DW-1:0] last_rd;
    int            ref_hits, ref_misses;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CD; i++) begin rv[i] = 1'b0; rt[i] = '0; end
        last_rd = '0; ref_hits = 0; ref_misses = 0;
    endtask

    // One CPU access. Caller must be at a falling edge with the DUT idle.
    // dly = number of extra mem_req cycles before mem_ack is returned.
    task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int dly);
        logic          exp_hit;
        logic [DW-1:0] exp_rd;
        int lat, lat_ack, nmem, nwr, cnt, clash;
        logic done, seen_we;
        logic [AW-1:0] seen_addr;
        logic [DW-1:0] seen_wdata, wr_din;
        logic [2:0]    wr_idx;
        logic [2:0]    i;
        i       = a[2:0];
        exp_hit = rv[i] && (rt[i] == a[AW-1:3]);

        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        lat = 0; lat_ack = 0; nmem = 0; nwr = 0; cnt = 0; clash = 0; done = 1'b0;
        seen_we = 1'b0; seen_addr = '0; seen_wdata = '0; wr_din = '0; wr_idx = '0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            mem_ack = 1'b0; mem_rdata = DW'($urandom);
            if (mem_req && cache_wr_en) clash++;
            if (mem_req) begin
                nmem++; seen_we = mem_we; seen_addr = mem_addr; seen_wdata = mem_wdata;
                if (cnt == dly) begin
                    mem_ack = 1'b1; mem_rdata = mem[a[7:0]]; lat_ack = lat;
                end else cnt++;
            end
            if (cache_wr_en) begin nwr++; wr_idx = cache_index; wr_din = cache_din; end
            if (cpu_done) done = 1'b1;
        end
        chk("done_seen", 32'(done), 1);

        // Model update and expectations
        if (we) mem[a[7:0]] = wd;
        exp_rd = we ? last_rd : mem[a[7:0]];
        if (!we && !exp_hit) begin rv[i] = 1'b1; rt[i] = a[AW-1:3]; end
        if (exp_hit) ref_hits++; else ref_misses++;
        last_rd = exp_rd;

        chk("cpu_hit", 32'(cpu_hit), 32'(exp_hit));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
        chk("no_wr_with_memreq", clash, 0);
        chk("mem_req_cycles", nmem, (!we && exp_hit) ? 0 : dly + 1);
        chk("cache_wr_cycles", nwr, (we ? exp_hit : !exp_hit) ? 1 : 0);
        if (nmem > 0) begin
            chk("mem_we", 32'(seen_we), 32'(we));
            chk("mem_addr", seen_addr, a);
            if (we) chk("mem_wdata", 32'(seen_wdata), 32'(wd));
        end
        if (nwr > 0) begin
            chk("cache_index", 32'(wr_idx), 32'(i));
            chk("cache_din", 32'(wr_din), 32'(we ? wd : mem[a[7:0]]));
        end
        // Read hit: accept edge, then COMPARE->DONE edge. Read miss: the ack
        // edge, then FILL->DONE edge.
        if (!we && exp_hit)  chk("hit_latency", lat, 2);
        if (!we && !exp_hit) chk("miss_latency_after_ack", lat - lat_ack, 2);

        @(negedge clk);
        mem_ack = 1'b0;
        chk("done_pulse_one_cycle", 32'(cpu_done), 0);
        chk("ready_after_done", 32'(cpu_ready), 1);
    endtask

    task automatic chk_counters(input string tag);
`ifdef CACHE_STATS_EN
        chk({tag, "_hits"}, 32'(hit_count), ref_hits);
        chk({tag, "_misses"}, 32'(miss_count), ref_misses);
`else
        chk({tag, "_hits"}, 32'(hit_count), 0);
        chk({tag, "_misses"}, 32'(miss_count), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int k = 0; k < 256; k++) mem[k] = DW'($urandom);
        mem[8'h13] = 8'hA5;
        mem[8'h0B] = 8'h3C;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(cpu_ready), 1);
        chk("rst_done", 32'(cpu_done), 0);
        chk("rst_hit", 32'(cpu_hit), 0);
        chk("rst_rdata", 32'(cpu_rdata), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_cache_wr", 32'(cache_wr_en), 0);
        chk("rst_cache_rd", 32'(cache_rd_en), 0);
        chk_counters("rst");
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, then hit, then conflict replacement
        access(1'b0, 32'h13, 8'h00, 1);
        chk("first_read_data", 32'(cpu_rdata), 32'hA5);
        access(1'b0, 32'h13, 8'h00, 0);
        chk("hit_read_data", 32'(cpu_rdata), 32'hA5);
        access(1'b0, 32'h0B, 8'h00, 2);
        chk("conflict_read_data", 32'(cpu_rdata), 32'h3C);
        access(1'b0, 32'h13, 8'h00, 0);
        // Write hit updates line; write miss does not allocate
        access(1'b0, 32'h0B, 8'h00, 0);
        access(1'b1, 32'h0B, 8'h77, 1);
        access(1'b0, 32'h0B, 8'h00, 0);
        chk("read_after_write", 32'(cpu_rdata), 32'h77);
        access(1'b1, 32'h40, 8'h5A, 0);
        access(1'b0, 32'h40, 8'h00, 0);
        chk_counters("directed");

        // Reset while waiting in MEM_RD for a read miss of 0x13
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h13;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        w = 0;
        while (!mem_req && w < 10) begin @(negedge clk); w++; end
        chk("mid_mem_req_seen", 32'(mem_req), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 0);
        chk("mid_rst_ready", 32'(cpu_ready), 1);
        chk("mid_rst_rdata", 32'(cpu_rdata), 0);
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; reset = 1'b0;
        @(negedge clk); mem_ack = 1'b1;      // stray ack while idle
        @(negedge clk); mem_ack = 1'b0;
        chk("stray_ack_ready", 32'(cpu_ready), 1);
        chk("stray_ack_done", 32'(cpu_done), 0);
        chk("stray_ack_mem_req", 32'(mem_req), 0);
        model_reset();
        access(1'b0, 32'h13, 8'h00, 0);
        chk("post_reset_miss", 32'(cpu_hit), 0);

        // 3 hits + 2 misses since reset
        access(1'b0, 32'h13, 8'h00, 0);
        access(1'b0, 32'h13, 8'h00, 0);
        access(1'b0, 32'h13, 8'h00, 0);
        access(1'b0, 32'h21, 8'h00, 1);
        chk_counters("stats");

        // Randomized traffic over a small address space to force conflicts
        for (int n = 0; n < 60; n++)
            access(1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 31)),
                   DW'($urandom), int'($urandom_range(0, 3)));
        chk_counters("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
